// File: rtl/xif_offload_sched.sv
// Scheduler for CV-X-IF offloaded instructions: in-order queue that holds each
// accepted instruction until commit/kill, then returns results strictly in issue order.
module xif_offload_sched #(
    parameter int         X_ID_WIDTH = 4,
    parameter int         DEPTH      = 4,
    parameter logic [6:0] OPCODE     = 7'h0B
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]           issue_rs0_i,
    input  logic [31:0]           issue_rs1_i,
    input  logic [1:0]            issue_rs_valid_i,
    output logic                  issue_accept_o,
    output logic                  issue_writeback_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [4:0]            result_rd_o,
    output logic [31:0]           result_data_o,
    output logic                  result_we_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ISSUED    = 2'd1,
        COMMITTED = 2'd2,
        KILLED    = 2'd3
    } ent_state_e;

    ent_state_e            state_q [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
    logic [4:0]            rd_q    [DEPTH];
    logic [31:0]           data_q  [DEPTH];

    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;

    logic       match, full, push, pop, same_id_commit;
    ent_state_e head_state, commit_state;
    logic       unused_instr;

    assign unused_instr = ^issue_instr_i[31:12];

    assign match             = (issue_instr_i[6:0] == OPCODE);
    assign full              = (count_q == DEPTH_C);
    assign issue_accept_o    = match;
    assign issue_writeback_o = match;
    assign issue_ready_o     = !match || ((issue_rs_valid_i == 2'b11) && !full);
    assign push              = issue_valid_i && issue_ready_o && match;

    // Result side depends only on registered head state, never on inputs.
    assign head_state     = state_q[head_q];
    assign result_valid_o = (head_state == COMMITTED);
    assign result_we_o    = result_valid_o;
    assign pop            = (head_state == KILLED) || (result_valid_o && result_ready_i);

    assign result_id_o   = result_valid_o ? id_q[head_q]   : '0;
    assign result_rd_o   = result_valid_o ? rd_q[head_q]   : '0;
    assign result_data_o = result_valid_o ? data_q[head_q] : '0;

    assign commit_state   = commit_kill_i ? KILLED : COMMITTED;
    assign same_id_commit = commit_valid_i && (commit_id_i == issue_id_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && (state_q[i] == ISSUED) && (id_q[i] == commit_id_i))
                    state_q[i] <= commit_state;
            end
            // Pop and push never target the same slot: a pop needs count > 0, a push count < DEPTH.
            if (pop) begin
                state_q[head_q] <= EMPTY;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                state_q[tail_q] <= same_id_commit ? commit_state : ISSUED;
                tail_q          <= tail_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; the entry state alone decides validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[tail_q]   <= issue_id_i;
            rd_q[tail_q]   <= issue_instr_i[11:7];
            data_q[tail_q] <= issue_rs0_i + issue_rs1_i;
        end
    end

endmodule
